// File: rtl/led_scanner.sv
// ---------------------------------------------------------------------------
// led_scanner
//   Width-generic one-hot LED scanner with a programmable step rate and four
//   run modes (bounce, wrap up, wrap down, hold). A prescaler counts enabled
//   cycles. When it expires, the scan position moves one step according to
//   the current mode. All outputs come from registers and change on the same
//   edge as the step that causes them.
//
// Parameters
//   N_LEDS  number of LEDs / one-hot width (2..64)
//   DIV_W   prescaler counter and i_div width
//   POS_W   derived index width, leave at default
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    asynchronous reset, active-high
//   i_en     1 = prescaler runs, 0 = everything frozen, pulses forced low
//   i_clr    synchronous restart (pos 0, moving up, prescaler 0)
//   i_mode   00 bounce, 01 wrap up, 10 wrap down, 11 hold
//   i_div    step every i_div+1 enabled cycles
//   o_led    one-hot LED drive, bit o_pos set
//   o_pos    current lit index
//   o_dir    1 = moving up, 0 = moving down
//   o_tick   one-cycle pulse, a step happened on the previous edge
//   o_wrap   one-cycle pulse, that step reached an end / reversal point
// ---------------------------------------------------------------------------
module led_scanner #(
    parameter int N_LEDS = 8,
    parameter int DIV_W  = 24,
    parameter int POS_W  = $clog2(N_LEDS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [1:0]        i_mode,
    input  logic [DIV_W-1:0]  i_div,
    output logic [N_LEDS-1:0] o_led,
    output logic [POS_W-1:0]  o_pos,
    output logic              o_dir,
    output logic              o_tick,
    output logic              o_wrap
);

    typedef enum logic [1:0] {
        MODE_BOUNCE    = 2'b00,
        MODE_WRAP_UP   = 2'b01,
        MODE_WRAP_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_e;

    typedef enum logic {
        S_DOWN = 1'b0,
        S_UP   = 1'b1
    } state_e;

    localparam logic [POS_W-1:0] POS_ZERO = '0;
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_LEDS - 1);

    mode_e mode;
    assign mode = mode_e'(i_mode);

    logic [DIV_W-1:0]  cnt_q,   cnt_d;
    logic [POS_W-1:0]  pos_q,   pos_d;
    state_e            state_q, state_d;
    logic [N_LEDS-1:0] led_q,   led_d;
    logic              tick_q,  tick_d;
    logic              wrap_q,  wrap_d;

    // '>=' rather than '==' so that lowering i_div below the running count
    // produces a step on the next enabled edge instead of a long rollover.
    logic step_due;
    assign step_due = (cnt_q >= i_div);

    // NOTE: every variable below gets a default before any branch, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        state_d = state_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (i_clr) begin
            cnt_d   = '0;
            pos_d   = POS_ZERO;
            state_d = S_UP;
        end else if (i_en) begin
            if (step_due) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                case (mode)
                    MODE_BOUNCE: begin
                        if (state_q == S_UP) begin
                            if (pos_q < POS_MAX) begin
                                pos_d = pos_q + POS_ONE;
                                if (pos_q == POS_MAX - POS_ONE) begin
                                    state_d = S_DOWN;
                                    wrap_d  = 1'b1;
                                end
                            end else begin
                                // Already at the top while moving up (left
                                // there by a wrap mode): turn back quietly.
                                pos_d   = POS_MAX - POS_ONE;
                                state_d = S_DOWN;
                            end
                        end else begin
                            if (pos_q != POS_ZERO) begin
                                pos_d = pos_q - POS_ONE;
                                if (pos_q == POS_ONE) begin
                                    state_d = S_UP;
                                    wrap_d  = 1'b1;
                                end
                            end else begin
                                pos_d   = POS_ONE;
                                state_d = S_UP;
                            end
                        end
                    end
                    MODE_WRAP_UP: begin
                        state_d = S_UP;
                        if (pos_q >= POS_MAX) begin
                            pos_d  = POS_ZERO;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end
                    MODE_WRAP_DOWN: begin
                        state_d = S_DOWN;
                        if (pos_q == POS_ZERO) begin
                            pos_d  = POS_MAX;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                        end
                    end
                    MODE_HOLD: begin
                        pos_d   = pos_q;
                        state_d = state_q;
                    end
                    default: begin
                        pos_d   = pos_q;
                        state_d = state_q;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        led_d = N_LEDS'(1) << pos_d;
    end

    // NOTE: all state uses non-blocking assignments and an asynchronous
    // reset, so outputs are defined the instant i_rst rises, without a clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            pos_q   <= POS_ZERO;
            state_q <= S_UP;
            led_q   <= N_LEDS'(1);
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            state_q <= state_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_led  = led_q;
    assign o_pos  = pos_q;
    assign o_dir  = (state_q == S_UP);
    assign o_tick = tick_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_led_scanner.sv
// ---------------------------------------------------------------------------
// tb_led_scanner
//   Drives three scanner builds (8, 2 and 16 LEDs) from shared inputs. A
//   behavioural model tracks each one from the scanning rules. Directed
//   scenarios run first, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_led_scanner;

    localparam int DIV_W = 24;

    logic             clk;
    logic             rst;
    logic             en;
    logic             clr;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;

    logic [7:0]  led8;
    logic [2:0]  pos8;
    logic        dir8, tick8, wrap8;
    logic [1:0]  led2;
    logic [0:0]  pos2;
    logic        dir2, tick2, wrap2;
    logic [15:0] led16;
    logic [3:0]  pos16;
    logic        dir16, tick16, wrap16;

    led_scanner #(.N_LEDS(8), .DIV_W(DIV_W)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_mode(mode),
        .i_div(div), .o_led(led8), .o_pos(pos8), .o_dir(dir8),
        .o_tick(tick8), .o_wrap(wrap8)
    );

    led_scanner #(.N_LEDS(2), .DIV_W(DIV_W)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_mode(mode),
        .i_div(div), .o_led(led2), .o_pos(pos2), .o_dir(dir2),
        .o_tick(tick2), .o_wrap(wrap2)
    );

    led_scanner #(.N_LEDS(16), .DIV_W(DIV_W)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_mode(mode),
        .i_div(div), .o_led(led16), .o_pos(pos16), .o_dir(dir16),
        .o_tick(tick16), .o_wrap(wrap16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 -> 8 LEDs, 1 -> 2 LEDs, 2 -> 16 LEDs.
    int          n_of [3] = '{8, 2, 16};
    int          m_pos [3];
    bit          m_up  [3];
    bit          m_wrap[3];
    bit          m_tick;
    longint      m_cnt;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_tick = 0;
        for (int i = 0; i < 3; i++) begin
            m_pos[i]  = 0;
            m_up[i]   = 1;
            m_wrap[i] = 0;
        end
    endtask

    // One scan step for one build, from the mode rules.
    task automatic model_step(input int i);
        int n;
        n = n_of[i];
        m_wrap[i] = 0;
        case (mode)
            2'b00: begin
                if (m_up[i]) begin
                    if (m_pos[i] >= n - 1) begin
                        m_pos[i] = n - 2;
                        m_up[i]  = 0;
                    end else begin
                        m_pos[i] = m_pos[i] + 1;
                        if (m_pos[i] == n - 1) begin
                            m_up[i]   = 0;
                            m_wrap[i] = 1;
                        end
                    end
                end else begin
                    if (m_pos[i] <= 0) begin
                        m_pos[i] = 1;
                        m_up[i]  = 1;
                    end else begin
                        m_pos[i] = m_pos[i] - 1;
                        if (m_pos[i] == 0) begin
                            m_up[i]   = 1;
                            m_wrap[i] = 1;
                        end
                    end
                end
            end
            2'b01: begin
                m_up[i]   = 1;
                m_wrap[i] = (m_pos[i] == n - 1);
                m_pos[i]  = (m_pos[i] + 1) % n;
            end
            2'b10: begin
                m_up[i]   = 0;
                m_wrap[i] = (m_pos[i] == 0);
                m_pos[i]  = (m_pos[i] + n - 1) % n;
            end
            default: ;
        endcase
    endtask

    // Apply the current inputs to the model for one rising edge.
    task automatic model_edge();
        if (clr) begin
            model_reset();
        end else if (!en) begin
            m_tick = 0;
            for (int i = 0; i < 3; i++) m_wrap[i] = 0;
        end else if (m_cnt >= longint'(div)) begin
            m_cnt  = 0;
            m_tick = 1;
            for (int i = 0; i < 3; i++) model_step(i);
        end else begin
            m_cnt  = m_cnt + 1;
            m_tick = 0;
            for (int i = 0; i < 3; i++) m_wrap[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_led8"},  64'(led8),  64'(1) << m_pos[0]);
        check({tag, "_pos8"},  64'(pos8),  64'(m_pos[0]));
        check({tag, "_dir8"},  64'(dir8),  64'(m_up[0]));
        check({tag, "_tick8"}, 64'(tick8), 64'(m_tick));
        check({tag, "_wrap8"}, 64'(wrap8), 64'(m_wrap[0]));
        check({tag, "_led2"},  64'(led2),  64'(1) << m_pos[1]);
        check({tag, "_dir2"},  64'(dir2),  64'(m_up[1]));
        check({tag, "_tick2"}, 64'(tick2), 64'(m_tick));
        check({tag, "_wrap2"}, 64'(wrap2), 64'(m_wrap[1]));
        check({tag, "_led16"}, 64'(led16), 64'(1) << m_pos[2]);
        check({tag, "_pos16"}, 64'(pos16), 64'(m_pos[2]));
        check({tag, "_dir16"}, 64'(dir16), 64'(m_up[2]));
        check({tag, "_wrap16"}, 64'(wrap16), 64'(m_wrap[2]));
    endtask

    // Model one edge, let it happen, then compare 1 time unit later.
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    int wrap_cnt;
    int tick_cnt;

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        clr  = 1'b0;
        mode = 2'b00;
        div  = '0;
        model_reset();

        // Reset state while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #3 rst = 1'b0;

        // Bounce, step every cycle: 30 steps from position 0.
        en = 1'b1;
        wrap_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            cycle("bounce");
            if (k < 28 && wrap8) wrap_cnt++;
        end
        check("bounce_wraps_28_steps", 64'(wrap_cnt), 64'd4);
        check("bounce_period14_pos8", 64'(pos8), 64'd2);
        check("bounce_period2_pos2", 64'(pos2), 64'd0);
        check("bounce_period30_pos16", 64'(pos16), 64'd0);
        check("bounce_period30_dir16", 64'(dir16), 64'd1);

        // Asynchronous reset in the middle of a run, at position 5.
        clr = 1'b1;
        cycle("pre_rst_clr");
        clr = 1'b0;
        repeat (5) cycle("pre_rst_run");
        check("pre_rst_pos8", 64'(pos8), 64'd5);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst_led8", 64'(led8), 64'd1);
        #2 rst = 1'b0;

        // Prescaler with i_div = 3: a tick every fourth cycle.
        div = 24'd3;
        clr = 1'b1;
        cycle("div_clr");
        clr = 1'b0;
        tick_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cycle("div3");
            if (tick8) tick_cnt++;
        end
        check("div3_ticks_in_12", 64'(tick_cnt), 64'd3);

        // Count reaches 3, then i_div drops to 1: step on the next edge.
        repeat (3) cycle("div3_count");
        div = 24'd1;
        cycle("div_lowered");
        check("div_lowered_tick", 64'(tick8), 64'd1);

        // Enable low for 10 cycles: frozen pattern, no pulses.
        en = 1'b0;
        repeat (10) cycle("en_low");
        en = 1'b1;

        // Wrap modes starting at position 6.
        div = '0;
        clr = 1'b1;
        cycle("wrap_clr");
        clr = 1'b0;
        repeat (6) cycle("to_pos6");
        mode = 2'b01;
        cycle("wrap_up");
        check("wrap_up_pos7", 64'(pos8), 64'd7);
        cycle("wrap_up");
        check("wrap_up_pos0", 64'(pos8), 64'd0);
        check("wrap_up_wrap", 64'(wrap8), 64'd1);
        cycle("wrap_up");
        check("wrap_up_pos1", 64'(pos8), 64'd1);
        mode = 2'b10;
        cycle("wrap_down");
        check("wrap_down_pos0", 64'(pos8), 64'd0);
        cycle("wrap_down");
        check("wrap_down_pos7", 64'(pos8), 64'd7);
        check("wrap_down_wrap", 64'(wrap8), 64'd1);
        mode = 2'b11;
        repeat (4) cycle("hold");
        check("hold_pos7", 64'(pos8), 64'd7);
        check("hold_tick", 64'(tick8), 64'd1);

        // Clear coincident with a due step at position 4.
        mode = 2'b00;
        clr = 1'b1;
        cycle("clr4_clr");
        clr = 1'b0;
        repeat (4) cycle("to_pos4");
        clr = 1'b1;
        cycle("clr_on_step");
        check("clr_on_step_tick", 64'(tick8), 64'd0);
        check("clr_on_step_pos", 64'(pos8), 64'd0);
        clr = 1'b0;

        // Randomized phase.
        for (int k = 0; k < 600; k++) begin
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) div = DIV_W'($urandom_range(0, 3));
            cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
